// File: rtl/mems_scan_pkg.sv
// Shared types and constants for the MEMS mirror DAC scan controller.
// Frame words are the 24-bit SPI payloads: [23:20] cmd, [19:16] addr, [15:0] data.
package mems_scan_pkg;

  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 8;
  localparam int DATA_W_MIN = 8;
  localparam int DATA_W_MAX = 16;

  localparam logic [23:0] FRAME_RESET = 24'h280001;
  localparam logic [23:0] FRAME_LDAC  = 24'h30000F;
  localparam logic [3:0]  CMD_WRITE   = 4'h1;

  typedef enum logic [1:0] {
    IDLE,
    SW_RESET,
    LDAC_SETUP,
    SCAN
  } scan_state_e;

endpackage

// File: rtl/mems_scan_ctrl_if.sv
// SPI frame launch handshake: one-cycle start pulse with a held 24-bit frame, busy while shifting.
// The controller waits for busy low (and no start in the previous cycle) before each launch.
interface mems_scan_ctrl_if;
  logic        spi_start;
  logic [23:0] spi_data;
  logic        spi_busy;

  modport master (output spi_start, output spi_data, input spi_busy);
  modport slave  (input spi_start, input spi_data, output spi_busy);
endinterface

// File: rtl/mems_axis_ramp.sv
// One scan axis: position register with sawtooth (or, with MEMS_SCAN_TRIANGLE_EN, triangle) stepping.
// Steps one cycle after carry_i; carry_o is combinational and reports that a step here would wrap/reverse.
module mems_axis_ramp
  import mems_scan_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              carry_i,
  input  logic              mode_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] hi_i,
  output logic [DATA_W-1:0] p_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic              carry_o
);

  logic [DATA_W-1:0] p_q, p_d, lo_q, lo_d, hi_q, hi_d;
  logic              degen, at_hi, at_lo;

  // lo >= hi pins the axis at lo and makes it carry on every step
  assign degen = (lo_q >= hi_q);
  assign at_hi = (p_q >= hi_q);
  assign at_lo = (p_q <= lo_q);

`ifdef MEMS_SCAN_TRIANGLE_EN
  logic dn_q, dn_d;

  assign carry_o = degen | ((mode_i & dn_q) ? at_lo : at_hi);

  always_ff @(posedge clk) begin
    if (rst) dn_q <= 1'b0;
    else     dn_q <= dn_d;
  end
`else
  logic unused_mode;

  assign unused_mode = mode_i;
  assign carry_o     = degen | at_hi;
`endif

  always_comb begin
    p_d  = p_q;
    lo_d = lo_q;
    hi_d = hi_q;
`ifdef MEMS_SCAN_TRIANGLE_EN
    dn_d = dn_q;
`endif
    if (load_i) begin
      p_d  = lo_i;
      lo_d = lo_i;
      hi_d = hi_i;
`ifdef MEMS_SCAN_TRIANGLE_EN
      dn_d = 1'b0;
`endif
    end else if (carry_i) begin
      if (carry_o) begin
        lo_d = lo_i;
        hi_d = hi_i;
      end
      if (degen) begin
        p_d = lo_i;
`ifdef MEMS_SCAN_TRIANGLE_EN
      end else if (mode_i) begin
        if (carry_o) dn_d = ~dn_q;
        p_d = (dn_q ^ carry_o) ? p_q - DATA_W'(1) : p_q + DATA_W'(1);
`endif
      end else begin
        p_d = at_hi ? lo_i : p_q + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q  <= '0;
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      p_q  <= p_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign p_o  = p_q;
  assign lo_o = lo_q;
  assign hi_o = hi_q;

endmodule

// File: rtl/mems_scan_ctrl.sv
// Raster scan controller for a differential MEMS DAC: init frames, then channel sweeps over SPI.
// One frame per launch-allowed cycle (spi_busy low, no start last cycle); MEMS_SCAN_TRIANGLE_EN adds triangle mode.
module mems_scan_ctrl
  import mems_scan_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       soft_reset,
  input  logic                       pause,
  input  logic                       mode,
  input  logic [NUM_CH/2*DATA_W-1:0] axis_lo,
  input  logic [NUM_CH/2*DATA_W-1:0] axis_hi,
  mems_scan_ctrl_if.master           spi,
  output logic                       running,
  output logic                       sweep_done
);

  localparam int NUM_AX = NUM_CH / 2;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  if ((NUM_CH % 2) != 0 || NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX ||
      DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_param
    $error("mems_scan_ctrl: unsupported NUM_CH/DATA_W");
  end

  scan_state_e       state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d, nxt_ch;
  logic              spi_start_q, spi_start_d;
  logic [23:0]       spi_data_q, spi_data_d;
  logic              sweep_done_q, sweep_done_d;
  logic              pend_q, pend_d;
  logic              launch_ok, restart, load_ax, step_ax;
  logic [NUM_AX-1:0] ax_en, ax_carry;
  logic [DATA_W-1:0] ax_p [NUM_AX];
  logic [DATA_W-1:0] ax_lo[NUM_AX];
  logic [DATA_W-1:0] ax_hi[NUM_AX];
  logic [DATA_W-1:0] ch_code[NUM_CH];

  for (genvar k = 0; k < NUM_AX; k++) begin : g_axis
    mems_axis_ramp #(.DATA_W(DATA_W)) u_axis (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load_ax),
      .carry_i (ax_en[k]),
      .mode_i  (mode),
      .lo_i    (axis_lo[k*DATA_W +: DATA_W]),
      .hi_i    (axis_hi[k*DATA_W +: DATA_W]),
      .p_o     (ax_p[k]),
      .lo_o    (ax_lo[k]),
      .hi_o    (ax_hi[k]),
      .carry_o (ax_carry[k])
    );
    assign ch_code[2*k]   = ax_p[k];
    assign ch_code[2*k+1] = DATA_W'(({1'b0, ax_lo[k]} + {1'b0, ax_hi[k]}) - {1'b0, ax_p[k]});
  end

  // Raster chain: each axis steps only when every lower axis carries out
  always_comb begin : carry_chain
    logic run;
    run = step_ax;
    for (int k = 0; k < NUM_AX; k++) begin
      ax_en[k] = run;
      run      = run & ax_carry[k];
    end
  end

  function automatic logic [23:0] scan_frame(input logic [CH_W-1:0] c, input logic [DATA_W-1:0] code);
    logic [15:0] d;
    d = 16'(code) << (16 - DATA_W);
    return {CMD_WRITE, 4'(c), d};
  endfunction

  assign launch_ok = ~spi.spi_busy & ~spi_start_q;
  assign restart   = (state_q == IDLE) ? soft_reset : (launch_ok & (pend_q | soft_reset));

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    spi_start_d  = 1'b0;
    spi_data_d   = spi_data_q;
    sweep_done_d = 1'b0;
    pend_d       = pend_q | soft_reset;
    load_ax      = 1'b0;
    step_ax      = 1'b0;
    nxt_ch       = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
    if (restart) begin
      state_d     = SW_RESET;
      ch_d        = '0;
      spi_start_d = 1'b1;
      spi_data_d  = FRAME_RESET;
      load_ax     = 1'b1;
      pend_d      = 1'b0;
    end else if (state_q == IDLE) begin
      pend_d = 1'b0;
    end else if (launch_ok) begin
      case (state_q)
        SW_RESET: begin
          state_d     = LDAC_SETUP;
          spi_start_d = 1'b1;
          spi_data_d  = FRAME_LDAC;
        end
        LDAC_SETUP: begin
          if (!pause) begin
            state_d     = SCAN;
            ch_d        = '0;
            spi_start_d = 1'b1;
            spi_data_d  = scan_frame('0, ch_code[0]);
          end
        end
        SCAN: begin
          // pause only blocks the start of a new sweep; a sweep in flight completes
          if (!(nxt_ch == '0 && pause)) begin
            ch_d        = nxt_ch;
            spi_start_d = 1'b1;
            spi_data_d  = scan_frame(nxt_ch, ch_code[nxt_ch]);
            if (nxt_ch == LAST_CH) begin
              sweep_done_d = 1'b1;
              step_ax      = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      spi_start_q  <= 1'b0;
      spi_data_q   <= '0;
      sweep_done_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      spi_start_q  <= spi_start_d;
      spi_data_q   <= spi_data_d;
      sweep_done_q <= sweep_done_d;
      pend_q       <= pend_d;
    end
  end

  assign spi.spi_start = spi_start_q;
  assign spi.spi_data  = spi_data_q;
  assign running       = (state_q != IDLE);
  assign sweep_done    = sweep_done_q;

endmodule

// File: tb/tb_mems_scan_ctrl.sv
// Bench for mems_scan_ctrl (NUM_CH=4, DATA_W=8) with an SPI slave that stays busy 3 cycles per frame.
module tb_mems_scan_ctrl;
  import mems_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_reset = 1'b0;
  logic        pause = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] axis_lo = '0;
  logic [15:0] axis_hi = '0;
  logic        running, sweep_done;

  mems_scan_ctrl_if sif();

  mems_scan_ctrl #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_reset (soft_reset),
    .pause      (pause),
    .mode       (mode),
    .axis_lo    (axis_lo),
    .axis_hi    (axis_hi),
    .spi        (sif),
    .running    (running),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [23:0] frames[$];
  logic [23:0] expq[$];

  assign sif.spi_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // SPI slave and frame recorder
  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (sif.spi_start) begin
      frames.push_back(sif.spi_data);
      busy_cnt = 3;
    end
    if (sweep_done) begin
      done_cnt++;
      check("sweep_done_on_ch3_launch", {27'd0, sif.spi_start, sif.spi_data[19:16]}, {27'd0, 1'b1, 4'd3});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic start_scan(input logic [7:0] l0, h0, l1, h1, input logic m);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    axis_lo = {l1, l0};
    axis_hi = {h1, h0};
    mode = m;
    frames.delete();
    done_cnt = 0;
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("frame_count_reached", {31'd0, frames.size() >= n}, 32'd1);
  endtask

  function automatic logic [23:0] frame_at(input int i);
    return (i < frames.size()) ? frames[i] : 24'hxxxxxx;
  endfunction

  // Reference: init frames, then each sweep emits p / mirror per axis, then the raster advances
  task automatic build_exp(input int l0, h0, l1, h1, input int ns, input bit tri_m);
    int p[2], lo[2], hi[2], code;
    bit dn[2];
    bit cy;
    lo[0] = l0; lo[1] = l1; hi[0] = h0; hi[1] = h1;
    p[0] = l0;  p[1] = l1;  dn[0] = 1'b0; dn[1] = 1'b0;
    expq.delete();
    expq.push_back(24'h280001);
    expq.push_back(24'h30000F);
    for (int s = 0; s < ns; s++) begin
      for (int c = 0; c < 4; c++) begin
        code = (c % 2 == 0) ? p[c/2] : ((lo[c/2] + hi[c/2] - p[c/2]) & 255);
        expq.push_back({4'h1, 4'(c), 8'(code), 8'h00});
      end
      cy = 1'b1;
      for (int k = 0; k < 2; k++) begin
        if (cy) begin
          if (lo[k] >= hi[k]) begin
            p[k] = lo[k];
            cy = 1'b1;
          end else if (!tri_m) begin
            cy = (p[k] == hi[k]);
            p[k] = cy ? lo[k] : p[k] + 1;
          end else if (!dn[k]) begin
            cy = (p[k] == hi[k]);
            p[k] = cy ? p[k] - 1 : p[k] + 1;
            dn[k] = cy;
          end else begin
            cy = (p[k] == lo[k]);
            p[k] = cy ? p[k] + 1 : p[k] - 1;
            dn[k] = !cy;
          end
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] lo0, hi0, lo1, hi1;
    int         sweep;
    logic [7:0] exp_code[4];
  } vec_t;

  function automatic vec_t mk(input int l0, h0, l1, h1, sw, c0, c1, c2, c3);
    vec_t v;
    v.lo0 = 8'(l0); v.hi0 = 8'(h0); v.lo1 = 8'(l1); v.hi1 = 8'(h1);
    v.sweep = sw;
    v.exp_code[0] = 8'(c0); v.exp_code[1] = 8'(c1);
    v.exp_code[2] = 8'(c2); v.exp_code[3] = 8'(c3);
    return v;
  endfunction

  vec_t vecs[7];

  initial begin
    int n, ch3s, ns;
    logic [7:0] l0, h0, l1, h1;
    bit tri_m;

    vecs[0] = mk(21, 161, 5, 9, 0, 21, 161, 5, 9);
    vecs[1] = mk(21, 161, 5, 9, 140, 161, 21, 5, 9);
    vecs[2] = mk(21, 161, 5, 9, 141, 21, 161, 6, 8);
    vecs[3] = mk(50, 50, 0, 3, 2, 50, 50, 2, 1);
    vecs[4] = mk(0, 1, 10, 12, 5, 1, 0, 12, 10);
    vecs[5] = mk(200, 100, 7, 7, 3, 200, 100, 7, 7);
    vecs[6] = mk(250, 255, 0, 255, 6, 250, 255, 1, 254);

    tick(3);
    check("reset_spi_start", {31'd0, sif.spi_start}, 32'd0);
    check("reset_spi_data", {8'd0, sif.spi_data}, 32'd0);
    check("reset_running", {31'd0, running}, 32'd0);
    check("reset_sweep_done", {31'd0, sweep_done}, 32'd0);
    rst = 1'b0;
    tick(10);
    check("idle_no_launch", frames.size(), 0);

    foreach (vecs[i]) begin
      start_scan(vecs[i].lo0, vecs[i].hi0, vecs[i].lo1, vecs[i].hi1, 1'b0);
      n = 2 + 4 * (vecs[i].sweep + 1);
      wait_frames(n, 4 * n + 40);
      check($sformatf("v%0d_frame_reset", i), {8'd0, frame_at(0)}, {8'd0, FRAME_RESET});
      check($sformatf("v%0d_frame_ldac", i), {8'd0, frame_at(1)}, {8'd0, FRAME_LDAC});
      for (int c = 0; c < 4; c++)
        check($sformatf("v%0d_sweep%0d_ch%0d", i, vecs[i].sweep, c),
              {8'd0, frame_at(n - 4 + c)}, {8'd0, 4'h1, 4'(c), vecs[i].exp_code[c], 8'h00});
      ch3s = 0;
      foreach (frames[j]) if (frames[j][23:16] == 8'h13) ch3s++;
      check($sformatf("v%0d_sweep_done_count", i), done_cnt, ch3s);
    end

    for (int r = 0; r < 5; r++) begin
      l0 = 8'($urandom_range(0, 240));
      h0 = (r == 4) ? l0 : l0 + 8'($urandom_range(1, 12));
      l1 = 8'($urandom_range(0, 250));
      h1 = l1 + 8'($urandom_range(0, 5));
      ns = $urandom_range(10, 40);
`ifdef MEMS_SCAN_TRIANGLE_EN
      tri_m = (r >= 2);
`else
      tri_m = 1'b0;
`endif
      start_scan(l0, h0, l1, h1, (r >= 2));
      build_exp(l0, h0, l1, h1, ns, tri_m);
      wait_frames(expq.size(), 4 * expq.size() + 40);
      for (int i = 0; i < expq.size(); i++)
        check($sformatf("rnd%0d_frame%0d", r, i), {8'd0, frame_at(i)}, {8'd0, expq[i]});
    end

    // pause raised while ch2 is shifting: ch3 still goes, then the scan holds before ch0
    start_scan(21, 161, 5, 9, 1'b0);
    wait_frames(5, 60);
    pause = 1'b1;
    tick(40);
    check("pause_frames_held", frames.size(), 6);
    check("pause_ch3_sent", {8'd0, frame_at(5)}, {8'd0, 24'h130900});
    check("pause_running", {31'd0, running}, 32'd1);
    pause = 1'b0;
    wait_frames(7, 40);
    check("pause_resume_ch0", {8'd0, frame_at(6)}, {8'd0, 24'h101600});

    // soft_reset while ch1 is shifting
    start_scan(21, 161, 5, 9, 1'b0);
    wait_frames(4, 60);
    soft_reset = 1'b1;
    tick(1);
    soft_reset = 1'b0;
    wait_frames(7, 60);
    check("sr_frame_reset", {8'd0, frame_at(4)}, {8'd0, FRAME_RESET});
    check("sr_frame_ldac", {8'd0, frame_at(5)}, {8'd0, FRAME_LDAC});
    check("sr_ch0_lo", {8'd0, frame_at(6)}, {8'd0, 24'h101500});

    // rst in the middle of a frame abandons the sequence
    start_scan(21, 161, 5, 9, 1'b0);
    wait_frames(3, 60);
    rst = 1'b1;
    tick(1);
    check("rst_spi_start", {31'd0, sif.spi_start}, 32'd0);
    check("rst_spi_data", {8'd0, sif.spi_data}, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    rst = 1'b0;
    n = frames.size();
    tick(40);
    check("rst_no_more_frames", frames.size(), n);
    check("rst_stays_idle", {31'd0, running}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
